// File: rtl/fire_zone_scheduler.sv
// Multi-zone fire supervisor: debounces per-zone smoke, raises alarms and shares one
// extinguisher pump between zones with a round-robin prime/spray/handoff sequence.
module fire_zone_scheduler #(
    parameter int NUM_ZONES      = 4,
    parameter int CONFIRM_CYCLES = 8,
    parameter int PRIME_CYCLES   = 4,
    parameter int DWELL_CYCLES   = 100,
    localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_ZONES-1:0] smoke_signal,
    input  logic [NUM_ZONES-1:0] heat_signal,
    output logic [NUM_ZONES-1:0] zone_alarm,
    output logic                 alarm,
    output logic [NUM_ZONES-1:0] valve_sel,
    output logic                 pump_on,
    output logic [ZW-1:0]        active_zone,
    output logic                 busy,
    output logic [1:0]           fsm_state
);

    localparam int MAXC_A = (CONFIRM_CYCLES > PRIME_CYCLES) ? CONFIRM_CYCLES : PRIME_CYCLES;
    localparam int MAXC   = (MAXC_A > DWELL_CYCLES) ? MAXC_A : DWELL_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0]        CONF_MAX   = CW'(CONFIRM_CYCLES);
    localparam logic [CW-1:0]        PRIME_LAST = CW'(PRIME_CYCLES - 1);
    localparam logic [CW-1:0]        DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]        CNT_ONE    = CW'(1);
    localparam logic [NUM_ZONES-1:0] ZONE_ONE   = NUM_ZONES'(1);
    localparam logic [ZW-1:0]        LAST_ZONE  = ZW'(NUM_ZONES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        SPRAY   = 2'd2,
        HANDOFF = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          conf_cnt  [NUM_ZONES];
    logic [CW-1:0]          conf_next [NUM_ZONES];
    logic [NUM_ZONES-1:0]   zone_alarm_next;
    logic [NUM_ZONES-1:0]   req;
    logic [ZW-1:0]          last_grant;
    logic [ZW-1:0]          last_grant_next;
    logic [ZW-1:0]          active_zone_next;
    logic [ZW-1:0]          grant_idx;
    logic                   grant_found;
    int                     arb_cand;
    logic [NUM_ZONES-1:0]   valve_next;
    logic                   pump_next;
    logic [CW-1:0]          tcnt;
    logic [CW-1:0]          tcnt_next;
    logic                   req_cur;

    // Saturating confirm counters; alarm asserts on the edge the count reaches the threshold.
    always_comb begin
        for (int i = 0; i < NUM_ZONES; i++) begin
            conf_next[i] = '0;
            if (smoke_signal[i]) begin
                conf_next[i] = (conf_cnt[i] == CONF_MAX) ? CONF_MAX : conf_cnt[i] + CNT_ONE;
            end
            zone_alarm_next[i] = (conf_next[i] == CONF_MAX);
        end
    end

    assign req = zone_alarm & heat_signal;

    // Search starts just after the last served zone so it becomes lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        arb_cand    = 0;
        for (int i = 1; i <= NUM_ZONES; i++) begin
            arb_cand = (int'(last_grant) + i) % NUM_ZONES;
            if (!grant_found && req[arb_cand]) begin
                grant_found = 1'b1;
                grant_idx   = ZW'(arb_cand);
            end
        end
    end

    assign req_cur = req[active_zone];

    always_comb begin
        state_next       = state;
        valve_next       = valve_sel;
        pump_next        = pump_on;
        active_zone_next = active_zone;
        last_grant_next  = last_grant;
        tcnt_next        = tcnt;
        case (state)
            IDLE: begin
                valve_next = '0;
                pump_next  = 1'b0;
                if (grant_found) begin
                    valve_next       = ZONE_ONE << grant_idx;
                    active_zone_next = grant_idx;
                    last_grant_next  = grant_idx;
                    tcnt_next        = '0;
                    state_next       = PRIME;
                end
            end
            PRIME: begin
                if (!req_cur) begin
                    valve_next = '0;
                    tcnt_next  = '0;
                    state_next = HANDOFF;
                end else if (tcnt == PRIME_LAST) begin
                    pump_next  = 1'b1;
                    tcnt_next  = '0;
                    state_next = SPRAY;
                end else begin
                    tcnt_next = tcnt + CNT_ONE;
                end
            end
            SPRAY: begin
                // Valve and pump drop together so the valve never moves under a running pump.
                if (!req_cur || tcnt == DWELL_LAST) begin
                    pump_next  = 1'b0;
                    valve_next = '0;
                    tcnt_next  = '0;
                    state_next = HANDOFF;
                end else begin
                    tcnt_next = tcnt + CNT_ONE;
                end
            end
            HANDOFF: begin
                valve_next = '0;
                pump_next  = 1'b0;
                tcnt_next  = '0;
                state_next = IDLE;
            end
            default: begin
                valve_next = '0;
                pump_next  = 1'b0;
                tcnt_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            zone_alarm  <= '0;
            alarm       <= 1'b0;
            valve_sel   <= '0;
            pump_on     <= 1'b0;
            active_zone <= '0;
            last_grant  <= LAST_ZONE;
            tcnt        <= '0;
            for (int i = 0; i < NUM_ZONES; i++) begin
                conf_cnt[i] <= '0;
            end
        end else begin
            state       <= state_next;
            zone_alarm  <= zone_alarm_next;
            alarm       <= |zone_alarm;
            valve_sel   <= valve_next;
            pump_on     <= pump_next;
            active_zone <= active_zone_next;
            last_grant  <= last_grant_next;
            tcnt        <= tcnt_next;
            for (int i = 0; i < NUM_ZONES; i++) begin
                conf_cnt[i] <= conf_next[i];
            end
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_fire_zone_scheduler.sv
// Bench for fire_zone_scheduler: directed stimulus pushes the expected output changes
// (value and cycle) into a queue; a monitor pops one entry per observed output change.
module tb_fire_zone_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] smoke_signal;
    logic [3:0] heat_signal;
    logic [3:0] zone_alarm;
    logic       alarm;
    logic [3:0] valve_sel;
    logic       pump_on;
    logic [1:0] active_zone;
    logic       busy;
    logic [1:0] fsm_state;

    fire_zone_scheduler #(
        .NUM_ZONES(4),
        .CONFIRM_CYCLES(8),
        .PRIME_CYCLES(4),
        .DWELL_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .smoke_signal(smoke_signal),
        .heat_signal(heat_signal),
        .zone_alarm(zone_alarm),
        .alarm(alarm),
        .valve_sel(valve_sel),
        .pump_on(pump_on),
        .active_zone(active_zone),
        .busy(busy),
        .fsm_state(fsm_state)
    );

    // Clock and cycle count
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [12:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [12:0] exp_now;
    int          errors = 0;
    int          checks = 0;
    logic        done = 1'b0;

    // Observed vector: {zone_alarm, alarm, valve_sel, pump_on, active_zone, busy}
    function automatic logic [12:0] mk(input logic [3:0] za, input logic al,
                                       input logic [3:0] vs, input logic po,
                                       input logic [1:0] az, input logic bz);
        return {za, al, vs, po, az, bz};
    endfunction

    task automatic push(input logic [12:0] v, input int at);
        exp_q.push_back(v);
        exp_cyc_q.push_back(at);
        exp_now = v;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        smoke_signal = '0;
        heat_signal  = '0;
        if (exp_now != 13'd0) push(13'd0, cyc);
        step(2);
        reset = 1'b1;
        step(2);
    endtask

    // Monitor
    logic [12:0] prev = '1;
    logic [12:0] obs;
    logic [12:0] ev;
    int          ev_at;
    logic [3:0]  prev_valve = '0;
    logic        prev_pump = 1'b0;

    always @(negedge clk) begin
        obs = {zone_alarm, alarm, valve_sel, pump_on, active_zone, busy};
        checks++;
        if (!(valve_sel == 4'd0 || $onehot(valve_sel)) || (pump_on && valve_sel == 4'd0) ||
            (pump_on && prev_pump && valve_sel != prev_valve)) begin
            errors++;
            $display("FAIL invariant cyc=%0d valve_sel=%b pump_on=%b prev_valve_sel=%b",
                     cyc, valve_sel, pump_on, prev_valve);
        end
        if (obs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, obs);
            end else begin
                ev    = exp_q.pop_front();
                ev_at = exp_cyc_q.pop_front();
                if (obs !== ev || (ev_at >= 0 && ev_at != cyc)) begin
                    errors++;
                    $display("FAIL output_event got=%b at cyc %0d required=%b at cyc %0d",
                             obs, cyc, ev, ev_at);
                end
            end
        end
        prev       = obs;
        prev_valve = valve_sel;
        prev_pump  = pump_on;
        if (done) begin
            while (exp_q.size() != 0) begin
                checks++;
                errors++;
                ev    = exp_q.pop_front();
                ev_at = exp_cyc_q.pop_front();
                $display("FAIL missing_event got=none required=%b at cyc %0d", ev, ev_at);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // Stimulus
    initial begin
        int t;
        int b;
        logic [1:0] order [3];
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd3;
        reset        = 1'b0;
        smoke_signal = '0;
        heat_signal  = '0;
        push(13'd0, -1);
        step(3);
        reset = 1'b1;
        step(2);

        // Debounce: 7-cycle pulse is ignored, 8-cycle pulse confirms then clears
        smoke_signal = 4'b0010;
        step(7);
        smoke_signal = '0;
        step(4);
        t = cyc;
        smoke_signal = 4'b0010;
        push(mk(4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0), t + 8);
        push(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0), t + 9);
        push(13'd0, t + 10);
        step(8);
        smoke_signal = '0;
        step(4);

        // Single zone 2: full dwell, handoff, regrant, then reset mid-spray
        t = cyc;
        smoke_signal = 4'b0100;
        heat_signal  = 4'b0100;
        push(mk(4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0), t + 8);
        push(mk(4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1), t + 9);
        push(mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1), t + 13);
        push(mk(4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1), t + 113);
        push(mk(4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0), t + 114);
        push(mk(4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1), t + 115);
        push(mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1), t + 119);
        step(150);
        do_reset();

        // Fairness across zones 0,1,3, then early release of zone 0 on its second grant
        t = cyc;
        smoke_signal = 4'b1011;
        heat_signal  = 4'b1011;
        push(mk(4'b1011, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0), t + 8);
        for (int k = 0; k < 3; k++) begin
            b = t + 9 + 106 * k;
            push(mk(4'b1011, 1'b1, 4'b0001 << order[k], 1'b0, order[k], 1'b1), b);
            push(mk(4'b1011, 1'b1, 4'b0001 << order[k], 1'b1, order[k], 1'b1), b + 4);
            push(mk(4'b1011, 1'b1, 4'b0000, 1'b0, order[k], 1'b1), b + 104);
            push(mk(4'b1011, 1'b1, 4'b0000, 1'b0, order[k], 1'b0), b + 105);
        end
        push(mk(4'b1011, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1), t + 327);
        push(mk(4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1), t + 331);
        push(mk(4'b1011, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1), t + 362);
        push(mk(4'b1011, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0), t + 363);
        push(mk(4'b1011, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b1), t + 364);
        step(361);
        heat_signal = 4'b1010;
        step(5);
        do_reset();

        // Smoke without heat on every zone: alarms only, pump stays idle
        t = cyc;
        smoke_signal = 4'b1111;
        push(mk(4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0), t + 8);
        push(mk(4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0), t + 9);
        push(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0), t + 21);
        push(13'd0, t + 22);
        step(20);
        smoke_signal = '0;
        step(5);
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=no summary required=summary before 100000ns");
        $fatal(1, "timeout");
    end

endmodule
